// File: rtl/scratch_access_arbiter.sv
// Round-robin arbiter of NUM_CLIENTS FSM masters (plus test-port override) onto a dual-port scratch memory.
// Optional macro SCRATCH_FWD_EN: same-cycle write->read forwarding on a shared address.
module scratch_access_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int NUM_CLIENTS = 4,
  parameter int MEM_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          test_mode,
  input  logic                          test_rd_req,
  input  logic [ADDR_W-1:0]             test_rd_addr,
  input  logic                          test_wr_en,
  input  logic [ADDR_W-1:0]             test_wr_addr,
  input  logic [DATA_W-1:0]             test_wr_data,
  output logic                          test_rd_valid,
  input  logic [NUM_CLIENTS-1:0]        cl_rd_req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_rd_addr,
  output logic [NUM_CLIENTS-1:0]        cl_rd_gnt,
  input  logic [NUM_CLIENTS-1:0]        cl_wr_req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_wr_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wr_data,
  output logic [NUM_CLIENTS-1:0]        cl_wr_gnt,
  output logic [NUM_CLIENTS-1:0]        rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic [ADDR_W-1:0]             mem_wr_addr,
  output logic [DATA_W-1:0]             mem_wr_data,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_rd_addr,
  input  logic [DATA_W-1:0]             mem_rd_data
);

  localparam int CW     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int STAGES = MEM_LAT + 1;

  function automatic logic [NUM_CLIENTS-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                     input logic [CW-1:0] ptr);
    logic [NUM_CLIENTS-1:0] gnt;
    logic                   found;
    gnt   = '0;
    found = 1'b0;
    // First pass covers ptr..top, second pass covers the wrapped part.
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!found && req[i] && (CW'(i) >= ptr)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [CW-1:0] oh_to_idx(input logic [NUM_CLIENTS-1:0] oh);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (oh[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] ptr_next(input logic [CW-1:0] idx);
    if (idx == CW'(NUM_CLIENTS - 1)) return '0;
    return idx + 1'b1;
  endfunction

  logic [CW-1:0]          rd_ptr, wr_ptr;
  logic [NUM_CLIENTS-1:0] rd_gnt_c, wr_gnt_c;
  logic [CW-1:0]          rd_idx, wr_idx;
  logic                   rd_issue, wr_issue;
  logic [ADDR_W-1:0]      rd_sel_addr, wr_sel_addr;
  logic [DATA_W-1:0]      wr_sel_data;
  logic [DATA_W-1:0]      rd_ret;

  logic                   vld_p  [STAGES];
  logic                   test_p [STAGES];
  logic [CW-1:0]          idx_p  [STAGES];

  always_comb begin
    rd_gnt_c    = '0;
    wr_gnt_c    = '0;
    if (!test_mode) begin
      rd_gnt_c = rr_pick(cl_rd_req, rd_ptr);
      wr_gnt_c = rr_pick(cl_wr_req, wr_ptr);
    end
    rd_idx      = oh_to_idx(rd_gnt_c);
    wr_idx      = oh_to_idx(wr_gnt_c);
    rd_sel_addr = test_rd_addr;
    wr_sel_addr = test_wr_addr;
    wr_sel_data = test_wr_data;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (rd_gnt_c[i]) rd_sel_addr = cl_rd_addr[i*ADDR_W +: ADDR_W];
      if (wr_gnt_c[i]) begin
        wr_sel_addr = cl_wr_addr[i*ADDR_W +: ADDR_W];
        wr_sel_data = cl_wr_data[i*DATA_W +: DATA_W];
      end
    end
    rd_issue = test_mode ? test_rd_req : (|rd_gnt_c);
    wr_issue = test_mode ? test_wr_en  : (|wr_gnt_c);
  end

  assign cl_rd_gnt = rd_gnt_c;
  assign cl_wr_gnt = wr_gnt_c;

`ifdef SCRATCH_FWD_EN
  logic              fwd_p      [MEM_LAT];
  logic [DATA_W-1:0] fwd_data_p [MEM_LAT];
  logic              fwd_hit;

  assign fwd_hit = mem_wr_en && vld_p[0] && (mem_wr_addr == mem_rd_addr);

  // Forward flag/data ride alongside the tag; entry k lines up with vld_p[k+1].
  always_ff @(posedge clk) begin
    fwd_p[0]      <= fwd_hit;
    fwd_data_p[0] <= mem_wr_data;
    for (int s = 1; s < MEM_LAT; s++) begin
      fwd_p[s]      <= fwd_p[s-1];
      fwd_data_p[s] <= fwd_data_p[s-1];
    end
  end

  assign rd_ret = fwd_p[MEM_LAT-1] ? fwd_data_p[MEM_LAT-1] : mem_rd_data;
`else
  assign rd_ret = mem_rd_data;
`endif

  // Stage p0: command register and tag-pipe entry; last stage aligns with mem_rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      mem_rd_addr   <= '0;
      rd_valid      <= '0;
      test_rd_valid <= 1'b0;
      rd_data       <= '0;
      for (int s = 0; s < STAGES; s++) vld_p[s] <= 1'b0;
    end else begin
      if (|rd_gnt_c) rd_ptr <= ptr_next(rd_idx);
      if (|wr_gnt_c) wr_ptr <= ptr_next(wr_idx);
      mem_wr_en <= wr_issue;
      if (wr_issue) begin
        mem_wr_addr <= wr_sel_addr;
        mem_wr_data <= wr_sel_data;
      end
      if (rd_issue) mem_rd_addr <= rd_sel_addr;
      vld_p[0] <= rd_issue;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
      rd_valid      <= '0;
      test_rd_valid <= 1'b0;
      if (vld_p[STAGES-1]) begin
        rd_data <= rd_ret;
        if (test_p[STAGES-1]) test_rd_valid <= 1'b1;
        else                  rd_valid      <= NUM_CLIENTS'(1) << idx_p[STAGES-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    test_p[0] <= test_mode;
    idx_p[0]  <= rd_idx;
    for (int s = 1; s < STAGES; s++) begin
      test_p[s] <= test_p[s-1];
      idx_p[s]  <= idx_p[s-1];
    end
  end

endmodule

// File: tb/tb_scratch_access_arbiter.sv
// Directed bench for scratch_access_arbiter with a read-first, 1-cycle-latency scratch memory model.
module tb_scratch_access_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int NC     = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   test_mode, test_rd_req, test_wr_en;
  logic [ADDR_W-1:0]      test_rd_addr, test_wr_addr;
  logic [DATA_W-1:0]      test_wr_data;
  logic                   test_rd_valid;
  logic [NC-1:0]          cl_rd_req, cl_rd_gnt, cl_wr_req, cl_wr_gnt, rd_valid;
  logic [NC*ADDR_W-1:0]   cl_rd_addr, cl_wr_addr;
  logic [NC*DATA_W-1:0]   cl_wr_data;
  logic [DATA_W-1:0]      rd_data, mem_wr_data, mem_rd_data;
  logic [ADDR_W-1:0]      mem_wr_addr, mem_rd_addr;
  logic                   mem_wr_en;

  logic                   mem_init;
  logic [DATA_W-1:0]      mem [2**ADDR_W];
  int                     checks = 0;
  int                     errors = 0;
  logic [DATA_W-1:0]      fwd_exp;

  scratch_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CLIENTS(NC), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .test_mode(test_mode),
    .test_rd_req(test_rd_req), .test_rd_addr(test_rd_addr),
    .test_wr_en(test_wr_en), .test_wr_addr(test_wr_addr), .test_wr_data(test_wr_data),
    .test_rd_valid(test_rd_valid),
    .cl_rd_req(cl_rd_req), .cl_rd_addr(cl_rd_addr), .cl_rd_gnt(cl_rd_gnt),
    .cl_wr_req(cl_wr_req), .cl_wr_addr(cl_wr_addr), .cl_wr_data(cl_wr_data), .cl_wr_gnt(cl_wr_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory preload: word a holds 32'hC000_0000 | a, except the top word which is 0.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 2**ADDR_W; a++)
        mem[a] <= (a == 2**ADDR_W - 1) ? 32'h0 : (32'hC000_0000 | 32'(a));
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef SCRATCH_FWD_EN
    fwd_exp = 32'h1234_5678;
`else
    fwd_exp = 32'h0;
`endif
    reset = 1'b1; mem_init = 1'b1; test_mode = 1'b0;
    test_rd_req = 1'b0; test_rd_addr = '0; test_wr_en = 1'b0; test_wr_addr = '0; test_wr_data = '0;
    cl_rd_req = '0; cl_rd_addr = '0; cl_wr_req = '0; cl_wr_addr = '0; cl_wr_data = '0;
    repeat (3) tick();
    mem_init = 1'b0;
    check("rst_rd_valid", rd_valid, 4'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_mem_wr_en", mem_wr_en, 1'b0);
    check("rst_mem_rd_addr", mem_rd_addr, 11'h0);
    check("rst_test_rd_valid", test_rd_valid, 1'b0);
    reset = 1'b0;

    // Round-robin reads, all four clients requesting.
    cl_rd_addr = {11'h103, 11'h102, 11'h101, 11'h100};
    cl_rd_req = 4'b1111; #1;
    check("rr_gnt0", cl_rd_gnt, 4'b0001);
    tick();
    check("rr_gnt1", cl_rd_gnt, 4'b0010);
    check("rr_addr0", mem_rd_addr, 11'h100);
    tick();
    check("rr_gnt2", cl_rd_gnt, 4'b0100);
    check("rr_addr1", mem_rd_addr, 11'h101);
    check("rr_noval", rd_valid, 4'b0000);
    tick();
    check("rr_gnt3", cl_rd_gnt, 4'b1000);
    check("rr_val0", rd_valid, 4'b0001);
    check("rr_data0", rd_data, 32'hC000_0100);
    tick();
    check("rr_gnt_wrap", cl_rd_gnt, 4'b0001);
    check("rr_val1", rd_valid, 4'b0010);
    check("rr_data1", rd_data, 32'hC000_0101);
    tick();
    cl_rd_req = 4'b0000; #1;
    check("rr_val2", rd_valid, 4'b0100);
    check("rr_data2", rd_data, 32'hC000_0102);
    tick();
    check("rr_val3", rd_valid, 4'b1000);
    check("rr_data3", rd_data, 32'hC000_0103);
    tick();
    check("rr_val0b", rd_valid, 4'b0001);
    check("rr_data0b", rd_data, 32'hC000_0100);
    tick();
    check("rr_idle", rd_valid, 4'b0000);

    // Concurrent write (client 2) and read (client 1).
    cl_wr_addr = {11'h000, 11'h040, 11'h000, 11'h000};
    cl_wr_data = {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
    cl_rd_addr = {11'h000, 11'h000, 11'h010, 11'h000};
    cl_wr_req = 4'b0100; cl_rd_req = 4'b0010; #1;
    check("par_rd_gnt", cl_rd_gnt, 4'b0010);
    check("par_wr_gnt", cl_wr_gnt, 4'b0100);
    tick();
    cl_wr_req = '0; cl_rd_req = '0; #1;
    check("par_wr_en", mem_wr_en, 1'b1);
    check("par_wr_addr", mem_wr_addr, 11'h040);
    check("par_wr_data", mem_wr_data, 32'hDEAD_BEEF);
    check("par_rd_addr", mem_rd_addr, 11'h010);
    tick();
    check("par_wr_pulse", mem_wr_en, 1'b0);
    check("par_rd_hold", mem_rd_addr, 11'h010);
    tick();
    check("par_val", rd_valid, 4'b0010);
    check("par_data", rd_data, 32'hC000_0010);

    // Same-cycle write and read of 11'h7FF (old value 0), both from client 3.
    cl_wr_addr = {11'h7FF, 11'h000, 11'h000, 11'h000};
    cl_wr_data = {32'h1234_5678, 32'h0, 32'h0, 32'h0};
    cl_rd_addr = {11'h7FF, 11'h000, 11'h000, 11'h000};
    cl_wr_req = 4'b1000; cl_rd_req = 4'b1000; #1;
    check("col_rd_gnt", cl_rd_gnt, 4'b1000);
    check("col_wr_gnt", cl_wr_gnt, 4'b1000);
    tick();
    cl_wr_req = '0; cl_rd_req = '0;
    tick();
    tick();
    check("col_val", rd_valid, 4'b1000);
    check("col_data", rd_data, fwd_exp);
    cl_rd_addr = {11'h000, 11'h000, 11'h000, 11'h7FF};
    cl_rd_req = 4'b0001; #1;
    check("col_reread_gnt", cl_rd_gnt, 4'b0001);
    tick();
    cl_rd_req = '0;
    tick();
    tick();
    check("col_reread_data", rd_data, 32'h1234_5678);
    check("col_reread_val", rd_valid, 4'b0001);

    // Test port writes are ignored outside test mode.
    test_wr_en = 1'b1; test_wr_addr = 11'h005; test_wr_data = 32'hFFFF_FFFF;
    tick();
    test_wr_en = 1'b0;
    check("test_ignored", mem_wr_en, 1'b0);

    // Client 3 read in flight when test mode rises; test port then owns the memory.
    cl_rd_addr = {11'h033, 11'h000, 11'h000, 11'h000};
    cl_rd_req = 4'b1000; #1;
    check("inflight_gnt", cl_rd_gnt, 4'b1000);
    tick();
    test_mode = 1'b1;
    cl_rd_req = 4'b0101; cl_wr_req = 4'b0001;
    test_wr_en = 1'b1; test_wr_addr = 11'h005; test_wr_data = 32'hA5A5_A5A5; #1;
    check("tm_rd_gnt", cl_rd_gnt, 4'b0000);
    check("tm_wr_gnt", cl_wr_gnt, 4'b0000);
    tick();
    test_wr_en = 1'b0; test_rd_req = 1'b1; test_rd_addr = 11'h005; #1;
    check("tm_wr_en", mem_wr_en, 1'b1);
    check("tm_wr_addr", mem_wr_addr, 11'h005);
    check("tm_wr_data", mem_wr_data, 32'hA5A5_A5A5);
    check("tm_rd_gnt2", cl_rd_gnt, 4'b0000);
    tick();
    test_rd_req = 1'b0;
    check("tm_rd_addr", mem_rd_addr, 11'h005);
    check("inflight_val", rd_valid, 4'b1000);
    check("inflight_data", rd_data, 32'hC000_0033);
    tick();
    check("tm_noval", test_rd_valid, 1'b0);
    tick();
    check("tm_rd_valid", test_rd_valid, 1'b1);
    check("tm_rd_data", rd_data, 32'hA5A5_A5A5);
    check("tm_cl_noval", rd_valid, 4'b0000);
    tick();
    check("tm_pulse", test_rd_valid, 1'b0);

    // Leaving test mode: frozen pointer (0) grants client 0 first.
    cl_wr_req = '0; test_mode = 1'b0; #1;
    check("drop_gnt0", cl_rd_gnt, 4'b0001);
    tick();
    check("drop_gnt2", cl_rd_gnt, 4'b0100);
    tick();
    cl_rd_req = '0;
    repeat (4) tick();

    // Reset during an in-flight read.
    cl_rd_addr = {11'h000, 11'h000, 11'h021, 11'h000};
    cl_rd_req = 4'b0010; #1;
    check("abort_gnt", cl_rd_gnt, 4'b0010);
    tick();
    cl_rd_req = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_rd_valid", rd_valid, 4'b0000);
    check("abort_rd_data", rd_data, 32'h0);
    check("abort_mem_rd_addr", mem_rd_addr, 11'h0);
    check("abort_mem_wr_en", mem_wr_en, 1'b0);
    check("abort_mem_wr_data", mem_wr_data, 32'h0);
    tick();
    check("abort_no_return", rd_valid, 4'b0000);
    cl_rd_req = 4'b0110; #1;
    check("abort_ptr_reset", cl_rd_gnt, 4'b0010);
    tick();
    cl_rd_req = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
